vector_alu_sequencer: RTL and testbench



---
 rtl/vector_alu_sequencer.sv | 144 ++++++++++++++
 tb/tb_vector_alu_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_alu_sequencer.sv
// vector_alu_sequencer
//   Runs one full-width vector ALU op (addv/subv/mulv/xor class) through a
//   narrower shared ALU slice. The operands and the op are latched on Start.
//   One chunk of ALU_LANES elements is issued per cycle, lowest chunk first.
//   Each chunk result is written back into the full-width Result, and the
//   upstream pipeline is stalled until the op completes.
//
// Optional feature (macro VSEQ_ZERO_FLAG_EN):
//   When defined, ResultZero is a sticky "whole result is zero" flag. It is
//   valid in DONE and held until the next accepted Start.
//   When undefined, ResultZero is tied to 0.
//
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   Start         vector ALU op valid from the execute stage
//   ALUControlIn  op from the ALU decoder
//   SrcA, SrcB    full-width vector operands (element 0 in the LSBs)
//   AluA, AluB    chunk operands to the shared ALU (0 outside RUN)
//   AluControl    op to the shared ALU (0 outside RUN)
//   AluResult     combinational chunk result from the shared ALU
//   Stall         hold the upstream pipeline
//   Busy          sequencer not idle
//   Done          one-cycle pulse, Result valid
//   Result        assembled vector result
//   ResultZero    zero flag for the vector branch/flag path
module vector_alu_sequencer #(
  parameter int LANES     = 16,
  parameter int ALU_LANES = 4,
  parameter int ELEM_W    = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        Start,
  input  logic [2:0]                  ALUControlIn,
  input  logic [LANES*ELEM_W-1:0]     SrcA,
  input  logic [LANES*ELEM_W-1:0]     SrcB,
  output logic [ALU_LANES*ELEM_W-1:0] AluA,
  output logic [ALU_LANES*ELEM_W-1:0] AluB,
  output logic [2:0]                  AluControl,
  input  logic [ALU_LANES*ELEM_W-1:0] AluResult,
  output logic                        Stall,
  output logic                        Busy,
  output logic                        Done,
  output logic [LANES*ELEM_W-1:0]     Result,
  output logic                        ResultZero
);

  localparam int PASSES  = LANES / ALU_LANES;
  localparam int CW      = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int CHUNK_W = ALU_LANES * ELEM_W;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Latched request; operands are viewed as PASSES chunks of ALU_LANES elements.
  typedef struct packed {
    logic [2:0]                       op;
    logic [PASSES-1:0][CHUNK_W-1:0]   a;
    logic [PASSES-1:0][CHUNK_W-1:0]   b;
  } req_t;

  state_t                         state, state_n;
  logic [CW-1:0]                  cnt;
  req_t                           req;
  logic [PASSES-1:0][CHUNK_W-1:0] res;
  logic                           accept, last;

  assign accept = (state == IDLE) && Start;
  assign last   = (cnt == CW'(PASSES-1));

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (Start) state_n = RUN;
      RUN:     if (last)  state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, counter, operand latch and result assembly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      req   <= '0;
      res   <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        req.op <= ALUControlIn;
        req.a  <= SrcA;
        req.b  <= SrcB;
        cnt    <= '0;
      end else if (state == RUN) begin
        cnt <= last ? '0 : cnt + 1'b1;
        // The loop over chunks keeps the select in range when PASSES is 1.
        for (int p = 0; p < PASSES; p++)
          if (cnt == CW'(p)) res[p] <= AluResult;
      end
    end
  end

  // Chunk issue. Outputs are forced to 0 outside RUN so the shared ALU sees quiet inputs.
  always_comb begin
    AluA       = '0;
    AluB       = '0;
    AluControl = '0;
    if (state == RUN) begin
      AluControl = req.op;
      for (int p = 0; p < PASSES; p++)
        if (cnt == CW'(p)) begin
          AluA = req.a[p];
          AluB = req.b[p];
        end
    end
  end

  assign Result = res;
  assign Busy   = (state != IDLE);
  assign Done   = (state == DONE);
  // Stall drops in DONE so the pipeline advances on the same cycle as Done.
  assign Stall  = (state == RUN) || accept;

`ifdef VSEQ_ZERO_FLAG_EN
  logic zflag;

  // The first RUN cycle seeds the AND-chain instead of reading the value
  // that was cleared on accept.
  always_ff @(posedge clk) begin
    if (reset)
      zflag <= 1'b0;
    else if (accept)
      zflag <= 1'b0;
    else if (state == RUN)
      zflag <= ((cnt == '0) ? 1'b1 : zflag) & (AluResult == '0);
  end

  assign ResultZero = zflag;
`else
  assign ResultZero = 1'b0;
`endif

endmodule

// File: tb/tb_vector_alu_sequencer.sv
module tb_vector_alu_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef VSEQ_ZERO_FLAG_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic         reset, start0, start1;
  logic [2:0]   op;
  logic [127:0] srca, srcb;

  // u0: 16 lanes over 4 ALUs
  logic [31:0]  a0, b0, r0;
  logic [2:0]   ctl0;
  logic         stall0, busy0, done0, rz0;
  logic [127:0] result0;

  // u1: 16 lanes over 16 ALUs (single pass)
  logic [127:0] a1, b1, r1;
  logic [2:0]   ctl1;
  logic         stall1, busy1, done1, rz1;
  logic [127:0] result1;

  vector_alu_sequencer #(.LANES(16), .ALU_LANES(4), .ELEM_W(8)) u0 (
    .clk(clk), .reset(reset), .Start(start0), .ALUControlIn(op),
    .SrcA(srca), .SrcB(srcb), .AluA(a0), .AluB(b0), .AluControl(ctl0),
    .AluResult(r0), .Stall(stall0), .Busy(busy0), .Done(done0),
    .Result(result0), .ResultZero(rz0));

  vector_alu_sequencer #(.LANES(16), .ALU_LANES(16), .ELEM_W(8)) u1 (
    .clk(clk), .reset(reset), .Start(start1), .ALUControlIn(op),
    .SrcA(srca), .SrcB(srcb), .AluA(a1), .AluB(b1), .AluControl(ctl1),
    .AluResult(r1), .Stall(stall1), .Busy(busy1), .Done(done1),
    .Result(result1), .ResultZero(rz1));

  // Shared-ALU model: per-element 8-bit add/sub/mul/xor.
  function automatic logic [7:0] ealu(input logic [7:0] x, input logic [7:0] y,
                                      input logic [2:0] o);
    case (o)
      3'b000:  return x + y;
      3'b001:  return x - y;
      3'b010:  return x * y;
      3'b101:  return x ^ y;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    r0 = '0;
    for (int i = 0; i < 4; i++) r0[i*8 +: 8] = ealu(a0[i*8 +: 8], b0[i*8 +: 8], ctl0);
  end
  always_comb begin
    r1 = '0;
    for (int i = 0; i < 16; i++) r1[i*8 +: 8] = ealu(a1[i*8 +: 8], b1[i*8 +: 8], ctl1);
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge (the drive point of a new cycle).
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  // Sample point in the current cycle.
  task automatic smp;
    @(negedge clk);
  endtask

  logic [127:0] ramp, ones, add_exp, sub_exp;

  // Full op on u0 starting in the current cycle T: checks Stall T..T+4,
  // chunk issue T+1..T+4, Done only at T+5, and the idle cycle at T+6.
  task automatic run0(input string tag, input logic [127:0] a, input logic [127:0] b,
                      input logic [2:0] o, input logic [127:0] exp_res, input logic exp_rz);
    start0 = 1'b1; srca = a; srcb = b; op = o;
    smp;
    chk({tag, "_stall_T"}, stall0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      nxt;
      start0 = 1'b0;
      smp;
      chk({tag, "_stall_run"}, stall0, 1'b1);
      chk({tag, "_done_run"}, done0, 1'b0);
      chk({tag, "_ctl_run"}, ctl0, o);
      chk({tag, "_aluA"}, a0, a[(k-1)*32 +: 32]);
    end
    nxt;
    smp;
    chk({tag, "_done"}, done0, 1'b1);
    chk({tag, "_stall_done"}, stall0, 1'b0);
    chk({tag, "_result"}, result0, exp_res);
    chk({tag, "_rz"}, rz0, exp_rz);
    nxt;
    smp;
    chk({tag, "_done_after"}, done0, 1'b0);
    chk({tag, "_busy_after"}, busy0, 1'b0);
    chk({tag, "_result_hold"}, result0, exp_res);
  endtask

  initial begin
    ramp    = 128'h0f0e0d0c0b0a09080706050403020100;
    ones    = {16{8'h01}};
    add_exp = 128'h100f0e0d0c0b0a090807060504030201;
    sub_exp = 128'hf6f7f8f9fafbfcfdfeff000102030405;

    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; op = '0; srca = '0; srcb = '0;
    nxt; nxt;
    smp;
    chk("rst_busy", busy0, 1'b0);
    chk("rst_stall", stall0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_result", result0, '0);
    chk("rst_rz", rz0, 1'b0);
    chk("rst_aluA", a0, '0);
    chk("rst_ctl", ctl0, '0);
    nxt;
    reset = 1'b0;

    // addv ramp + 1
    nxt;
    run0("addv", ramp, ones, 3'b000, add_exp, 1'b0);

    // wrap to zero, then one non-zero element
    nxt;
    run0("wrap", {16{8'hff}}, ones, 3'b000, '0, ZF);
    nxt;
    run0("wrap_nz", {16{8'hff}}, {8'h02, {15{8'h01}}}, 3'b000, {8'h01, 120'h0}, 1'b0);

    // Start held high: accepts at T, T+6, T+12
    nxt;
    start0 = 1'b1; op = 3'b001; srca = {16{8'h05}}; srcb = ramp;
    for (int c = 0; c < 18; c++) begin
      smp;
      chk("held_done", done0, (c % 6) == 5);
      chk("held_stall", stall0, (c % 6) != 5);
      chk("held_busy", busy0, (c % 6) != 0);
      chk("held_ctl", ctl0, ((c % 6) >= 1 && (c % 6) <= 4) ? 3'b001 : 3'b000);
      if ((c % 6) == 5) chk("held_result", result0, sub_exp);
      if (c < 17) nxt;
    end
    nxt;
    start0 = 1'b0;
    smp;
    chk("held_idle", busy0, 1'b0);

    // Start re-pulsed during RUN is ignored
    nxt;                                              // T
    start0 = 1'b1; srca = ramp; srcb = ones; op = 3'b000;
    nxt;                                              // T+1
    start0 = 1'b0;
    nxt;                                              // T+2
    start0 = 1'b1; srca = {16{8'haa}}; srcb = {16{8'h02}}; op = 3'b010;
    smp;
    chk("rep_ctl", ctl0, 3'b000);
    chk("rep_aluA1", a0, 32'h07060504);
    nxt;                                              // T+3
    smp;
    chk("rep_aluA2", a0, 32'h0b0a0908);
    nxt;                                              // T+4
    nxt;                                              // T+5
    smp;
    chk("rep_done", done0, 1'b1);
    chk("rep_result", result0, add_exp);
    chk("rep_stall_done", stall0, 1'b0);
    nxt;                                              // T+6: accepted
    smp;
    chk("rep_accept_busy", busy0, 1'b0);
    chk("rep_accept_stall", stall0, 1'b1);
    nxt;                                              // T+7
    start0 = 1'b0;
    smp;
    chk("rep2_busy", busy0, 1'b1);
    chk("rep2_ctl", ctl0, 3'b010);
    chk("rep2_aluA", a0, 32'haaaaaaaa);
    nxt; nxt; nxt;                                    // T+10
    smp;
    chk("rep2_done_early", done0, 1'b0);
    nxt;                                              // T+11
    smp;
    chk("rep2_done", done0, 1'b1);
    chk("rep2_result", result0, {16{8'h54}});

    // reset mid-RUN aborts
    nxt;                                              // T
    start0 = 1'b1; srca = {16{8'h11}}; srcb = ones; op = 3'b000;
    nxt;                                              // T+1
    start0 = 1'b0;
    nxt;                                              // T+2
    reset = 1'b1;
    smp;
    chk("rstrun_busy_pre", busy0, 1'b1);
    nxt;                                              // T+3
    reset = 1'b0;
    smp;
    chk("rstrun_busy", busy0, 1'b0);
    chk("rstrun_stall", stall0, 1'b0);
    chk("rstrun_result", result0, '0);
    chk("rstrun_done", done0, 1'b0);
    nxt;                                              // T+4
    run0("post_rst", ramp, ones, 3'b000, add_exp, 1'b0);

    // single-pass configuration
    nxt;                                              // T
    start1 = 1'b1; srca = ramp; srcb = ones; op = 3'b000;
    smp;
    chk("u1_stall_T", stall1, 1'b1);
    nxt;                                              // T+1
    start1 = 1'b0;
    smp;
    chk("u1_busy", busy1, 1'b1);
    chk("u1_aluA", a1, ramp);
    chk("u1_done_run", done1, 1'b0);
    nxt;                                              // T+2
    smp;
    chk("u1_done", done1, 1'b1);
    chk("u1_result", result1, add_exp);
    chk("u1_stall_done", stall1, 1'b0);
    nxt;
    start1 = 1'b1; srca = 128'hdeadbeef_01234567_89abcdef_55aa33cc;
    srcb = 128'hdeadbeef_01234567_89abcdef_55aa33cc; op = 3'b101;
    nxt;
    start1 = 1'b0;
    smp;
    chk("u1_xor_ctl", ctl1, 3'b101);
    nxt;
    smp;
    chk("u1_xor_done", done1, 1'b1);
    chk("u1_xor_result", result1, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
